// File: rtl/lke_ctrl_pkg.sv
// Shared definitions for the lookup-engine control path: header layout, resource IDs,
// FSM encoding and the beat/keep sizing helpers used by generator and stage parsers.
package lke_ctrl_pkg;

    localparam logic [15:0] CTRL_MAGIC_DEF = 16'hF2F1;

    localparam int HDR_MAGIC_LSB = 0;
    localparam int HDR_MAGIC_W   = 16;
    localparam int HDR_STAGE_LSB = 16;
    localparam int HDR_STAGE_W   = 5;
    localparam int HDR_RES_LSB   = 21;
    localparam int HDR_RES_W     = 4;
    localparam int HDR_ADDR_LSB  = 32;
    localparam int HDR_BEATS_LSB = 40;
    localparam int HDR_BEATS_W   = 8;
    localparam int HDR_LEN_W     = 16;

    localparam logic [3:0] RES_KEY_MASK = 4'h1;
    localparam logic [3:0] RES_CAM      = 4'h2;
    localparam logic [3:0] RES_ACT_RAM  = 4'h3;

    // Widest keep mask the helpers can describe (data width up to 2048 bits).
    localparam int KEEP_MAX = 256;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_DATA = 2'd2
    } ctrl_state_e;

    function automatic int data_beats(input int len, input int w);
        return (len + w - 1) / w;
    endfunction

    function automatic int last_bytes(input int len, input int w);
        int rem;
        rem = len - (data_beats(len, w) - 1) * w;
        return (rem + 7) / 8;
    endfunction

    function automatic logic [KEEP_MAX-1:0] last_keep(input int len, input int w);
        logic [KEEP_MAX-1:0] m;
        m = '0;
        for (int i = 0; i < KEEP_MAX; i++) begin
            if (i < last_bytes(len, w)) m[i] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/lke_ctrl_pkt_gen.sv
// Control-packet transmitter: turns one table-write request into a header beat followed
// by the entry payload, LSB first, on a registered AXI-Stream master.
module lke_ctrl_pkt_gen
    import lke_ctrl_pkg::*;
#(
    parameter int          C_S_AXIS_DATA_WIDTH  = 512,
    parameter int          C_S_AXIS_TUSER_WIDTH = 128,
    parameter int          ENTRY_LEN            = 625,
    parameter int          ADDR_WIDTH           = 8,
    parameter logic [15:0] CTRL_MAGIC           = CTRL_MAGIC_DEF
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 req_valid,
    output logic                                 req_ready,
    input  logic [4:0]                           req_stage_id,
    input  logic [3:0]                           req_resource_id,
    input  logic [ADDR_WIDTH-1:0]                req_addr,
    input  logic [ENTRY_LEN-1:0]                 req_data,
    output logic [C_S_AXIS_DATA_WIDTH-1:0]       c_m_axis_tdata,
    output logic [C_S_AXIS_TUSER_WIDTH-1:0]      c_m_axis_tuser,
    output logic [C_S_AXIS_DATA_WIDTH/8-1:0]     c_m_axis_tkeep,
    output logic                                 c_m_axis_tvalid,
    output logic                                 c_m_axis_tlast,
    input  logic                                 c_m_axis_tready,
    output logic                                 busy,
    output logic [31:0]                          pkt_cnt
);

    localparam int W          = C_S_AXIS_DATA_WIDTH;
    localparam int KW         = W / 8;
    localparam int UW         = C_S_AXIS_TUSER_WIDTH;
    localparam int DATA_BEATS = data_beats(ENTRY_LEN, W);
    localparam int PAD_W      = DATA_BEATS * W;
    localparam int BEAT_W     = (DATA_BEATS > 1) ? $clog2(DATA_BEATS) : 1;

    localparam logic [BEAT_W-1:0]    LAST_IDX      = BEAT_W'(DATA_BEATS - 1);
    localparam logic [KEEP_MAX-1:0]  LAST_KEEP_MAX = last_keep(ENTRY_LEN, W);
    localparam logic [KW-1:0]        LAST_KEEP     = LAST_KEEP_MAX[KW-1:0];
    localparam logic [HDR_LEN_W-1:0] PKT_BYTES     =
        HDR_LEN_W'(KW * DATA_BEATS + last_bytes(ENTRY_LEN, W));

    ctrl_state_e        r_state, w_state_nxt;
    logic               r_req_ready, w_req_ready_nxt;
    logic               r_tvalid, w_tvalid_nxt;
    logic               r_tlast, w_tlast_nxt;
    logic [W-1:0]       r_tdata, w_tdata_nxt;
    logic [KW-1:0]      r_tkeep, w_tkeep_nxt;
    logic [UW-1:0]      r_tuser, w_tuser_nxt;
    logic [PAD_W-1:0]   r_payload, w_payload_nxt;
    logic [BEAT_W-1:0]  r_beat, w_beat_nxt;
    logic [31:0]        r_pkt_cnt, w_pkt_cnt_nxt;

    logic               w_accept;
    logic               w_hs;
    logic [BEAT_W-1:0]  w_beat_inc;
    logic               w_next_last;
    logic [W-1:0]       w_hdr;

    // Request side: accept when req_valid && req_ready. Stream side: a beat moves only on
    // tvalid && tready; all beat fields are registers, so they hold while the sink stalls.
    assign w_accept    = req_valid & r_req_ready;
    assign w_hs        = r_tvalid & c_m_axis_tready;
    assign w_beat_inc  = r_beat + BEAT_W'(1);
    assign w_next_last = (w_beat_inc == LAST_IDX);

    always_comb begin
        w_hdr = '0;
        w_hdr[HDR_MAGIC_LSB +: HDR_MAGIC_W] = CTRL_MAGIC;
        w_hdr[HDR_STAGE_LSB +: HDR_STAGE_W] = req_stage_id;
        w_hdr[HDR_RES_LSB   +: HDR_RES_W]   = req_resource_id;
        w_hdr[HDR_ADDR_LSB  +: ADDR_WIDTH]  = req_addr;
        w_hdr[HDR_BEATS_LSB +: HDR_BEATS_W] = HDR_BEATS_W'(DATA_BEATS);
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_tvalid_nxt  = r_tvalid;
        w_tlast_nxt   = r_tlast;
        w_tdata_nxt   = r_tdata;
        w_tkeep_nxt   = r_tkeep;
        w_tuser_nxt   = r_tuser;
        w_payload_nxt = r_payload;
        w_beat_nxt    = r_beat;
        w_pkt_cnt_nxt = r_pkt_cnt;

        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt   = ST_HDR;
                    w_tvalid_nxt  = 1'b1;
                    w_tlast_nxt   = 1'b0;
                    w_tdata_nxt   = w_hdr;
                    w_tkeep_nxt   = '1;
                    w_tuser_nxt   = UW'(PKT_BYTES);
                    w_payload_nxt = PAD_W'(req_data);
                    w_beat_nxt    = '0;
                end
            end
            ST_HDR: begin
                w_beat_nxt = '0;
                if (w_hs) begin
                    w_state_nxt   = ST_DATA;
                    w_tdata_nxt   = r_payload[W-1:0];
                    w_payload_nxt = r_payload >> W;
                    w_tlast_nxt   = (DATA_BEATS == 1);
                    w_tkeep_nxt   = (DATA_BEATS == 1) ? LAST_KEEP : '1;
                end
            end
            ST_DATA: begin
                if (w_hs) begin
                    if (r_tlast) begin
                        w_state_nxt   = ST_IDLE;
                        w_tvalid_nxt  = 1'b0;
                        w_tlast_nxt   = 1'b0;
                        w_tdata_nxt   = '0;
                        w_tkeep_nxt   = '0;
                        w_tuser_nxt   = '0;
                        w_pkt_cnt_nxt = r_pkt_cnt + 32'd1;
                    end else begin
                        w_beat_nxt    = w_beat_inc;
                        w_tdata_nxt   = r_payload[W-1:0];
                        w_payload_nxt = r_payload >> W;
                        w_tlast_nxt   = w_next_last;
                        w_tkeep_nxt   = w_next_last ? LAST_KEEP : '1;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase

        w_req_ready_nxt = (w_state_nxt == ST_IDLE);
    end

    // req_ready is its own register so it stays low throughout reset and rises one clock after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_req_ready <= 1'b0;
            r_tvalid    <= 1'b0;
            r_tlast     <= 1'b0;
            r_tdata     <= '0;
            r_tkeep     <= '0;
            r_tuser     <= '0;
            r_payload   <= '0;
            r_beat      <= '0;
            r_pkt_cnt   <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_req_ready <= w_req_ready_nxt;
            r_tvalid    <= w_tvalid_nxt;
            r_tlast     <= w_tlast_nxt;
            r_tdata     <= w_tdata_nxt;
            r_tkeep     <= w_tkeep_nxt;
            r_tuser     <= w_tuser_nxt;
            r_payload   <= w_payload_nxt;
            r_beat      <= w_beat_nxt;
            r_pkt_cnt   <= w_pkt_cnt_nxt;
        end
    end

    assign req_ready       = r_req_ready;
    assign c_m_axis_tvalid = r_tvalid;
    assign c_m_axis_tlast  = r_tlast;
    assign c_m_axis_tdata  = r_tdata;
    assign c_m_axis_tkeep  = r_tkeep;
    assign c_m_axis_tuser  = r_tuser;
    assign busy            = (r_state != ST_IDLE);
    assign pkt_cnt         = r_pkt_cnt;

endmodule

// File: tb/tb_lke_ctrl_pkt_gen.sv
// Bench for lke_ctrl_pkt_gen: vector table on the default configuration, plus hand-written
// back-to-back, mid-packet reset and narrow/exact-width entry sequences.
module tb_lke_ctrl_pkt_gen;

    localparam int W  = 512;
    localparam int KW = 64;
    localparam int UW = 128;
    localparam int EL = 625;
    localparam int BW = 1 + KW + UW + W;

    typedef struct {
        logic [4:0]    stage;
        logic [3:0]    res;
        logic [7:0]    addr;
        logic [EL-1:0] data;
        logic [47:0]   hdr48;
        bit            rnd_ready;
    } vec_t;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- main DUT (defaults) ----------------
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [4:0]    req_stage_id = '0;
    logic [3:0]    req_resource_id = '0;
    logic [7:0]    req_addr = '0;
    logic [EL-1:0] req_data = '0;
    logic [W-1:0]  c_tdata;
    logic [UW-1:0] c_tuser;
    logic [KW-1:0] c_tkeep;
    logic          c_tvalid, c_tlast;
    logic          c_tready = 1'b0;
    logic          busy;
    logic [31:0]   pkt_cnt;

    lke_ctrl_pkt_gen u_dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_stage_id(req_stage_id), .req_resource_id(req_resource_id),
        .req_addr(req_addr), .req_data(req_data),
        .c_m_axis_tdata(c_tdata), .c_m_axis_tuser(c_tuser), .c_m_axis_tkeep(c_tkeep),
        .c_m_axis_tvalid(c_tvalid), .c_m_axis_tlast(c_tlast), .c_m_axis_tready(c_tready),
        .busy(busy), .pkt_cnt(pkt_cnt)
    );

    // ---------------- ENTRY_LEN=512 and ENTRY_LEN=1 instances ----------------
    logic          one = 1'b1;
    logic          b_req_valid = 1'b0, c_req_valid = 1'b0;
    logic          b_req_ready, c_req_ready;
    logic [4:0]    b_stage = '0, c_stage = '0;
    logic [3:0]    b_res = '0, c_res = '0;
    logic [7:0]    b_addr = '0, c_addr = '0;
    logic [511:0]  b_data = '0;
    logic [0:0]    c_data = '0;
    logic [W-1:0]  b_tdata, n_tdata;
    logic [UW-1:0] b_tuser, n_tuser;
    logic [KW-1:0] b_tkeep, n_tkeep;
    logic          b_tvalid, b_tlast, n_tvalid, n_tlast, b_busy, n_busy;
    logic [31:0]   b_pkt_cnt, n_pkt_cnt;

    lke_ctrl_pkt_gen #(.ENTRY_LEN(512)) u_dut_512 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(b_req_valid), .req_ready(b_req_ready),
        .req_stage_id(b_stage), .req_resource_id(b_res), .req_addr(b_addr), .req_data(b_data),
        .c_m_axis_tdata(b_tdata), .c_m_axis_tuser(b_tuser), .c_m_axis_tkeep(b_tkeep),
        .c_m_axis_tvalid(b_tvalid), .c_m_axis_tlast(b_tlast), .c_m_axis_tready(one),
        .busy(b_busy), .pkt_cnt(b_pkt_cnt)
    );

    lke_ctrl_pkt_gen #(.ENTRY_LEN(1)) u_dut_1 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(c_req_valid), .req_ready(c_req_ready),
        .req_stage_id(c_stage), .req_resource_id(c_res), .req_addr(c_addr), .req_data(c_data),
        .c_m_axis_tdata(n_tdata), .c_m_axis_tuser(n_tuser), .c_m_axis_tkeep(n_tkeep),
        .c_m_axis_tvalid(n_tvalid), .c_m_axis_tlast(n_tlast), .c_m_axis_tready(one),
        .busy(n_busy), .pkt_cnt(n_pkt_cnt)
    );

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_pass = 0;
    int acc_cyc = 0;
    int tlast_cyc = 0;
    int tready_mode = 0;  // 0: always ready, 1: random, 2: never
    logic [BW-1:0] exp_q[$];

    task automatic chk(input string name, input logic [1023:0] act, input logic [1023:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else n_pass++;
    endtask

    function automatic logic [BW-1:0] pack_beat(input logic last, input logic [KW-1:0] keep,
                                                 input logic [W-1:0] data);
        return {last, keep, UW'(143), data};
    endfunction

    task automatic push_pkt(input vec_t v);
        exp_q.push_back(pack_beat(1'b0, '1, W'(v.hdr48)));
        exp_q.push_back(pack_beat(1'b0, '1, v.data[W-1:0]));
        exp_q.push_back(pack_beat(1'b1, 64'h7FFF, W'(v.data[EL-1:W])));
    endtask

    always @(posedge clk) begin
        #1;
        case (tready_mode)
            0:       c_tready = 1'b1;
            1:       c_tready = ($urandom_range(0, 1) == 1);
            default: c_tready = 1'b0;
        endcase
    end

    logic          prev_stall = 1'b0;
    logic [BW-1:0] prev_beat = '0;
    logic [BW-1:0] exp_beat;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall)
                chk("stall_hold", 1024'({c_tvalid, c_tlast, c_tkeep, c_tuser, c_tdata}),
                    1024'({1'b1, prev_beat}));
            if (c_tvalid && c_tready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_beat: got beat %0h expected none", c_tdata);
                end else begin
                    exp_beat = exp_q.pop_front();
                    chk("beat", 1024'({c_tlast, c_tkeep, c_tuser, c_tdata}), 1024'(exp_beat));
                end
                if (c_tlast) tlast_cyc = cyc + 1;
            end
            prev_stall = c_tvalid && !c_tready;
            prev_beat  = {c_tlast, c_tkeep, c_tuser, c_tdata};
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_req(input vec_t v);
        int waited;
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!req_ready && waited < 200);
        if (!req_ready) begin
            n_checks++;
            $display("FAIL req_ready_timeout: got 0 expected 1 within 200 cycles");
            return;
        end
        req_stage_id    = v.stage;
        req_resource_id = v.res;
        req_addr        = v.addr;
        req_data        = v.data;
        req_valid       = 1'b1;
        @(posedge clk);
        #1;
        acc_cyc   = cyc;
        req_valid = 1'b0;
        // Scramble the inputs: the packet must come from the captured copy.
        req_stage_id    = ~req_stage_id;
        req_resource_id = ~req_resource_id;
        req_addr        = ~req_addr;
        req_data        = ~req_data;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(negedge clk);
        chk("drain", 1024'(exp_q.size()), 1024'(0));
        @(negedge clk);
    endtask

    // ---------------- test sequence ----------------
    vec_t vecs[4];
    int nb, nn;

    initial begin
        vecs[0] = '{5'd2,  4'h3, 8'h05, EL'(1),                         48'h02_05_0062_F2F1, 1'b0};
        vecs[1] = '{5'h1F, 4'h1, 8'hFF, '1,                             48'h02_FF_003F_F2F1, 1'b1};
        vecs[2] = '{5'd0,  4'h2, 8'h80, {1'b1, {39{16'hA5C3}}},         48'h02_80_0040_F2F1, 1'b1};
        vecs[3] = '{5'h0A, 4'hF, 8'h3C, (EL'(1) << 600) | EL'(32'hDEADBEEF), 48'h02_3C_01EA_F2F1, 1'b0};

        // Reset asserted mid-cycle: outputs zero at once, req_ready low.
        #2 rst_n = 1'b0;
        #1;
        chk("rst_outs", 1024'({c_tvalid, c_tlast, c_tkeep, c_tuser, c_tdata, busy, req_ready}), 1024'(0));
        chk("rst_pkt_cnt", 1024'(pkt_cnt), 1024'(0));
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("ready_after_rst", 1024'(req_ready), 1024'(1));

        // Vector table: one packet per entry, scoreboard checks every beat.
        for (int i = 0; i < 4; i++) begin
            tready_mode = vecs[i].rnd_ready ? 1 : 0;
            push_pkt(vecs[i]);
            send_req(vecs[i]);
            wait_drain();
            chk("pkt_cnt", 1024'(pkt_cnt), 1024'(i + 1));
            chk("idle_after_pkt", 1024'({busy, c_tvalid, req_ready}), 1024'(3'b001));
        end

        // Back-to-back requests with the sink always ready.
        tready_mode = 0;
        @(negedge clk);
        push_pkt(vecs[2]);
        push_pkt(vecs[3]);
        send_req(vecs[2]);
        send_req(vecs[3]);
        chk("b2b_accept_cycle", 1024'(acc_cyc), 1024'(tlast_cyc + 1));
        wait_drain();
        chk("b2b_pkt_cnt", 1024'(pkt_cnt), 1024'(6));

        // Reset during the first data beat, then a complete packet.
        push_pkt(vecs[0]);
        send_req(vecs[0]);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("midrst_outs", 1024'({c_tvalid, c_tlast, c_tkeep, c_tuser, c_tdata, busy, req_ready}), 1024'(0));
        chk("midrst_pkt_cnt", 1024'(pkt_cnt), 1024'(0));
        @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("midrst_ready", 1024'({req_ready, busy}), 1024'(2'b10));
        tready_mode = 1;
        push_pkt(vecs[1]);
        send_req(vecs[1]);
        wait_drain();
        chk("midrst_pkt_cnt_after", 1024'(pkt_cnt), 1024'(1));

        // ENTRY_LEN=512 (exact beat) and ENTRY_LEN=1 (single byte) instances.
        for (int i = 0; i < 20 && !(b_req_ready && c_req_ready); i++) @(negedge clk);
        chk("bn_ready", 1024'({b_req_ready, c_req_ready}), 1024'(2'b11));
        b_stage = 5'd0; b_res = 4'h1; b_addr = 8'hAA; b_data = {8{64'h0123_4567_89AB_CDEF}};
        c_stage = 5'd1; c_res = 4'h2; c_addr = 8'h01; c_data = 1'b1;
        b_req_valid = 1'b1;
        c_req_valid = 1'b1;
        @(posedge clk);
        #1;
        b_req_valid = 1'b0;
        c_req_valid = 1'b0;
        nb = 0;
        nn = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (b_tvalid) begin
                if (nb == 0)
                    chk("b512_hdr", 1024'({b_tlast, b_tkeep, b_tuser, b_tdata}),
                        1024'({1'b0, {KW{1'b1}}, UW'(128), W'(48'h01_AA_0020_F2F1)}));
                else
                    chk("b512_data", 1024'({b_tlast, b_tkeep, b_tuser, b_tdata}),
                        1024'({1'b1, {KW{1'b1}}, UW'(128), {8{64'h0123_4567_89AB_CDEF}}}));
                nb++;
            end
            if (n_tvalid) begin
                if (nn == 0)
                    chk("b1_hdr", 1024'({n_tlast, n_tkeep, n_tuser, n_tdata}),
                        1024'({1'b0, {KW{1'b1}}, UW'(65), W'(48'h01_01_0041_F2F1)}));
                else
                    chk("b1_data", 1024'({n_tlast, n_tkeep, n_tuser, n_tdata}),
                        1024'({1'b1, KW'(1), UW'(65), W'(1)}));
                nn++;
            end
        end
        chk("b512_beats", 1024'(nb), 1024'(2));
        chk("b1_beats", 1024'(nn), 1024'(2));
        chk("b512_pkt_cnt", 1024'(b_pkt_cnt), 1024'(1));
        chk("b1_pkt_cnt", 1024'(n_pkt_cnt), 1024'(1));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
